// File: rtl/mmio_pkg.sv
// Shared types for the data-memory responder: region decode, MMIO word offsets, TX_STAT layout.
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  localparam logic [23:0] MMIO_BASE_HI = 24'h80_0000;

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_CYC_LO  = 8'h04;
  localparam logic [7:0] OFF_CYC_HI  = 8'h08;
  localparam logic [7:0] OFF_TX_DATA = 8'h0C;
  localparam logic [7:0] OFF_TX_STAT = 8'h10;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_OVF     = 5;

  // Takes addr[31:8]; the low byte never affects the region.
  function automatic region_e decode_region(input logic [23:0] a_hi);
    if (a_hi[23:8] == 16'h0000) return REG_RAM;
    if (a_hi == MMIO_BASE_HI) return REG_MMIO;
    return REG_NONE;
  endfunction

  function automatic logic [2:0] sat_count(input logic [31:0] c);
    return (c > 32'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO for debug TX output; head visible combinationally, zero when empty.
// Pop is ignored when empty; a push while full is taken only if a pop frees the slot that cycle.
module mmio_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: RAM/MMIO decode, LED, cycle counter, TX FIFO; loads return 2 cycles
// after their address in every region. No backpressure toward the core; TX drains on valid/ready.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_ADDR_W = 14,
  parameter int TX_DEPTH   = 4,
  parameter int LED_W      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           dmem_addr_in,
  input  logic [31:0]           dmem_data_in,
  input  logic [3:0]            dmem_write_enable_in,
  output logic [31:0]           dmem_data_out,
  output logic [RAM_ADDR_W-1:0] ram_addr_out,
  output logic [31:0]           ram_data_out,
  output logic [3:0]            ram_we_out,
  input  logic [31:0]           ram_data_in,
  output logic [LED_W-1:0]      led_out,
  output logic [7:0]            tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  region_e          region, region_s1_q, region_s2_q;
  logic [7:0]       offset;
  logic [31:0]      mmio_rd, mmio_s1_q, mmio_s2_q;
  logic [LED_W-1:0] led_q, led_d;
  logic [63:0]      cyc_q;
  wire  [63:0]      cyc_d;
  logic             ovf_q, ovf_d;
  logic             mmio_wr, tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0]    tx_count;

  assign region       = decode_region(dmem_addr_in[31:8]);
  assign offset       = dmem_addr_in[7:0];
  assign ram_addr_out = dmem_addr_in[RAM_ADDR_W+1:2];
  assign ram_data_out = dmem_data_in;
  assign ram_we_out   = (region == REG_RAM) ? dmem_write_enable_in : 4'b0000;

  assign mmio_wr      = (region == REG_MMIO) && (dmem_write_enable_in != 4'b0000);
  assign tx_push      = mmio_wr && (offset == OFF_TX_DATA) && dmem_write_enable_in[0];
  assign tx_valid_out = !tx_empty;
  assign tx_pop       = tx_valid_out && tx_ready_in;
  assign cyc_d        = cyc_q + 64'd1;
  assign led_out      = led_q;

  // Read value is taken from current state, so a same-cycle write is not visible.
  always_comb begin
    mmio_rd = '0;
    if (region == REG_MMIO) begin
      case (offset)
        OFF_LED:    mmio_rd = 32'(led_q);
        OFF_CYC_LO: mmio_rd = cyc_q[31:0];
        OFF_CYC_HI: mmio_rd = cyc_q[63:32];
        OFF_TX_STAT: begin
          mmio_rd[STAT_FULL]            = tx_full;
          mmio_rd[STAT_EMPTY]           = tx_empty;
          mmio_rd[STAT_CNT_LSB +: 3]    = sat_count(32'(tx_count));
          mmio_rd[STAT_OVF]             = ovf_q;
        end
        default:    mmio_rd = '0;
      endcase
    end
  end

  always_comb begin
    led_d = led_q;
    if (mmio_wr && (offset == OFF_LED)) begin
      for (int b = 0; b < LED_W; b++) begin
        if (dmem_write_enable_in[b/8]) led_d[b] = dmem_data_in[b];
      end
    end
    ovf_d = ovf_q;
    if (tx_push && tx_full && !tx_pop) begin
      ovf_d = 1'b1;
    end else if (mmio_wr && (offset == OFF_TX_STAT) && dmem_write_enable_in[0]
                 && dmem_data_in[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      region_s1_q <= REG_NONE;
      region_s2_q <= REG_NONE;
      mmio_s1_q   <= '0;
      mmio_s2_q   <= '0;
      led_q       <= '0;
      cyc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      region_s1_q <= region;
      region_s2_q <= region_s1_q;
      mmio_s1_q   <= mmio_rd;
      mmio_s2_q   <= mmio_s1_q;
      led_q       <= led_d;
      cyc_q       <= cyc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign dmem_data_out = (region_s2_q == REG_RAM) ? ram_data_in : mmio_s2_q;

  mmio_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (tx_push),
    .data_i  (dmem_data_in[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (tx_data_out)
  );

endmodule
